// File: rtl/instr_asm_pkg.sv
// Shared constants for the RV32I instruction assembler: beat kinds, opcodes,
// the EBREAK halt word, FSM state encoding and an immediate range helper.
package instr_asm_pkg;

  localparam logic [2:0] KIND_OP_IMM  = 3'd0;
  localparam logic [2:0] KIND_OP      = 3'd1;
  localparam logic [2:0] KIND_STORE   = 3'd2;
  localparam logic [2:0] KIND_BRANCH  = 3'd3;
  localparam logic [2:0] KIND_JAL     = 3'd4;
  localparam logic [2:0] KIND_JALR    = 3'd5;
  localparam logic [2:0] KIND_EBREAK  = 3'd6;
  localparam logic [2:0] KIND_ILLEGAL = 3'd7;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCEPT  = 2'd1,
    ST_HALT_WR = 2'd2,
    ST_DONE    = 2'd3
  } asm_state_e;

  function automatic logic imm_in_range(input logic signed [20:0] v,
                                        input logic signed [20:0] lo,
                                        input logic signed [20:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational RV32I field packer. With INSTR_ASM_RANGE_CHECK_EN defined the
// immediate is range-checked per kind; otherwise it is truncated to the format.
module instr_encode
  import instr_asm_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [20:0] imm,
  output logic [31:0] word,
  output logic        bad
);

  logic range_bad;

  // Pack fields into the 32-bit encoding selected by kind.
  always_comb begin
    word = 32'h0000_0000;
    case (kind)
      KIND_OP_IMM: word = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
      KIND_OP:     word = {funct7, rs2, rs1, funct3, rd, OPC_OP};
      KIND_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      KIND_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3,
                           imm[4:1], imm[11], OPC_BRANCH};
      KIND_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      KIND_JALR:   word = {imm[11:0], rs1, funct3, rd, OPC_JALR};
      KIND_EBREAK: word = EBREAK_WORD;
      default:     word = 32'h0000_0000;
    endcase
  end

`ifdef INSTR_ASM_RANGE_CHECK_EN
  // JAL spans the full 21-bit signed range, so only its alignment matters.
  always_comb begin
    range_bad = 1'b0;
    case (kind)
      KIND_OP_IMM, KIND_STORE, KIND_JALR:
        range_bad = !imm_in_range($signed(imm), -21'sd2048, 21'sd2047);
      KIND_BRANCH:
        range_bad = imm[0] || !imm_in_range($signed(imm), -21'sd4096, 21'sd4094);
      KIND_JAL:
        range_bad = imm[0];
      default:
        range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  assign bad = (kind == KIND_ILLEGAL) || range_bad;

endmodule

// File: rtl/instr_assembler.sv
// Streaming RV32I assembler: encodes accepted beats into consecutive imem words
// and closes every program with EBREAK. Range checks via INSTR_ASM_RANGE_CHECK_EN.
module instr_assembler
  import instr_asm_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [20:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);

  asm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       enc_word;
  logic              enc_bad;

  instr_encode u_encode (
    .kind   (in_kind),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .word   (enc_word),
    .bad    (enc_bad)
  );

  assign in_ready = (state_q == ST_ACCEPT) && !start;

  // Next-state, write pointer and write-port decisions.
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    done_d       = done_q;
    err_d        = err_q;
    if (start) begin
      state_d = ST_ACCEPT;
      wptr_d  = {ADDR_W{1'b0}};
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_ACCEPT: begin
          // The top word is reserved for EBREAK, so reaching it aborts.
          if (wptr_q == LAST_ADDR) begin
            state_d = ST_HALT_WR;
            err_d   = 1'b1;
          end else if (in_valid) begin
            if (enc_bad) begin
              state_d = ST_HALT_WR;
              err_d   = 1'b1;
            end else begin
              imem_we_d    = 1'b1;
              imem_addr_d  = wptr_q;
              imem_wdata_d = enc_word;
              wptr_d       = wptr_q + ADDR_ONE;
              state_d      = in_last ? ST_HALT_WR : ST_ACCEPT;
            end
          end else begin
            state_d = ST_ACCEPT;
          end
        end
        ST_HALT_WR: begin
          imem_we_d    = 1'b1;
          imem_addr_d  = wptr_q;
          imem_wdata_d = EBREAK_WORD;
          state_d      = ST_DONE;
          if (wptr_q != LAST_ADDR) begin
            wptr_d = wptr_q + ADDR_ONE;
          end else begin
            wptr_d = wptr_q;
          end
        end
        ST_DONE: done_d = 1'b1;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wptr_q       <= {ADDR_W{1'b0}};
      imem_we_q    <= 1'b0;
      imem_addr_q  <= {ADDR_W{1'b0}};
      imem_wdata_q <= 32'h0000_0000;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Bench for instr_assembler: two instances (256-word and 4-word memories) share
// the stimulus; a per-cycle behavioural program model predicts every output.
module tb_instr_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, in_valid, in_last;
  logic [2:0]  in_kind, in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [20:0] in_imm;
  logic        rdy8, we8, done8, err8, rdy2, we2, done2, err2;
  logic [7:0]  addr8;
  logic [1:0]  addr2;
  logic [31:0] wd8, wd2;

  instr_assembler #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy8),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(we8), .imem_addr(addr8), .imem_wdata(wd8), .done(done8), .err(err8));

  instr_assembler #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy2),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2), .done(done2), .err(err2));

  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic [31:0] mem8 [256];
  logic [31:0] mem2 [4];
  always @(posedge clk) begin
    if (we8) mem8[addr8] <= wd8;
    if (we2) mem2[addr2] <= wd2;
  end

  int n_vec = 0;
  int n_err = 0;

  // Program model: one entry per instance.
  int          dep [2] = '{256, 4};
  bit          m_acc [2], m_halt [2], m_halted [2];
  int          m_addr [2];
  logic [31:0] e_we [2], e_addr [2], e_wdata [2], e_done [2], e_err [2];
  int          cur_imm;
  bit          last_hs;

  logic [2:0]  pk [8], pf3 [8];
  logic [6:0]  pf7 [8];
  logic [4:0]  prd [8], prs1 [8], prs2 [8];
  int          pimm [8];

  function automatic logic [31:0] ref_enc(input logic [2:0] k, input logic [31:0] f3,
      input logic [31:0] f7, input logic [31:0] rd, input logic [31:0] rs1,
      input logic [31:0] rs2, input int imm);
    logic [31:0] u;
    u = imm;
    case (k)
      3'd0: return ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
      3'd1: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      3'd2: return (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                   | ((u & 32'h1F) << 7) | 32'h23;
      3'd3: return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8)
                   | (((u >> 11) & 32'h1) << 7) | 32'h63;
      3'd4: return (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                   | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12)
                   | (rd << 7) | 32'h6F;
      3'd5: return ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h67;
      3'd6: return EBRK;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_bad(input logic [2:0] k, input int imm);
    if (k == 3'd7) return 1'b1;
`ifdef INSTR_ASM_RANGE_CHECK_EN
    case (k)
      3'd0, 3'd2, 3'd5: return (imm < -2048) || (imm > 2047);
      3'd3: return ((imm & 1) != 0) || (imm < -4096) || (imm > 4094);
      3'd4: return (imm & 1) != 0;
      default: return 1'b0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_acc[d] = 1'b0; m_halt[d] = 1'b0; m_halted[d] = 1'b0; m_addr[d] = 0;
      e_we[d] = 0; e_addr[d] = 0; e_wdata[d] = 0; e_done[d] = 0; e_err[d] = 0;
    end
  endtask

  task automatic check_outs();
    chk("we8", {31'b0, we8}, e_we[0]);      chk("we2", {31'b0, we2}, e_we[1]);
    chk("addr8", {24'b0, addr8}, e_addr[0]); chk("addr2", {30'b0, addr2}, e_addr[1]);
    chk("wdata8", wd8, e_wdata[0]);          chk("wdata2", wd2, e_wdata[1]);
    chk("done8", {31'b0, done8}, e_done[0]); chk("done2", {31'b0, done2}, e_done[1]);
    chk("err8", {31'b0, err8}, e_err[0]);    chk("err2", {31'b0, err2}, e_err[1]);
  endtask

  task automatic drive(input bit v, input logic [2:0] k, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input int imm, input bit last);
    in_valid = v; in_kind = k; in_funct3 = f3; in_funct7 = f7; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm[20:0]; cur_imm = imm; in_last = last;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 1'b0);
  endtask

  // One clock: check ready before the edge, advance the model, check after it.
  task automatic tick();
    #1;
    chk("ready8", {31'b0, rdy8}, {31'b0, m_acc[0] && !start});
    chk("ready2", {31'b0, rdy2}, {31'b0, m_acc[1] && !start});
    last_hs = !start && m_acc[0] && in_valid && (m_addr[0] != dep[0] - 1);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (start) begin
        m_acc[d] = 1'b1; m_addr[d] = 0; m_halt[d] = 1'b0; m_halted[d] = 1'b0;
        e_we[d] = 0; e_done[d] = 0; e_err[d] = 0;
      end else begin
        e_we[d] = 0;
        if (m_halt[d]) begin
          e_we[d] = 1; e_addr[d] = m_addr[d]; e_wdata[d] = EBRK;
          m_halt[d] = 1'b0; m_halted[d] = 1'b1;
        end else if (m_halted[d]) begin
          e_done[d] = 1;
        end
        if (m_acc[d]) begin
          if (m_addr[d] == dep[d] - 1) begin
            m_acc[d] = 1'b0; e_err[d] = 1; m_halt[d] = 1'b1;
          end else if (in_valid) begin
            if (ref_bad(in_kind, cur_imm)) begin
              m_acc[d] = 1'b0; e_err[d] = 1; m_halt[d] = 1'b1;
            end else begin
              e_we[d] = 1; e_addr[d] = m_addr[d];
              e_wdata[d] = ref_enc(in_kind, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, cur_imm);
              m_addr[d]++;
              if (in_last) begin
                m_acc[d] = 1'b0; m_halt[d] = 1'b1;
              end
            end
          end
        end
      end
    end
    #1 check_outs();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic idles(input int n);
    idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rand_beat(input int i, input bit any_kind, input bit wild_imm);
    pk[i]   = any_kind ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 5));
    pf3[i]  = 3'($urandom); pf7[i] = 7'($urandom);
    prd[i]  = 5'($urandom); prs1[i] = 5'($urandom); prs2[i] = 5'($urandom);
    if (wild_imm && ($urandom_range(0, 1) == 1))
      pimm[i] = int'($urandom_range(0, 2097151)) - 1048576;
    else
      pimm[i] = int'($urandom_range(0, 2047)) * 2 - 2048;
  endtask

  initial begin
    int nb, cyc, len;
    rst_n = 1'b0; start = 1'b0; idle(); model_reset();
    @(negedge clk);
    #1 check_outs();
    chk("rst ready8", {31'b0, rdy8}, 32'd0);
    rst_n = 1'b1;
    // IDLE must ignore beats until a start arrives.
    drive(1'b1, 3'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 5, 1'b1); tick(); tick();

    // Single OP_IMM program.
    do_start();
    drive(1'b1, 3'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 5, 1'b1); tick();
    idles(3);
    chk("tp1 mem0", mem8[0], 32'h0050_0093); chk("tp1 mem1", mem8[1], EBRK);
    chk("tp1 done", {31'b0, done8}, 32'd1); chk("tp1 err", {31'b0, err8}, 32'd0);
    chk("tp1 mem1 small", mem2[1], EBRK);

    // BRANCH then JAL.
    do_start();
    drive(1'b1, 3'd3, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -8, 1'b0); tick();
    drive(1'b1, 3'd4, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 2048, 1'b1); tick();
    idles(3);
    chk("tp2 mem0", mem8[0], 32'hFE20_8CE3); chk("tp2 mem1", mem8[1], 32'h0010_00EF);
    chk("tp2 mem2", mem8[2], EBRK);

    // Out-of-range I immediate.
    do_start();
    drive(1'b1, 3'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 2048, 1'b1); tick();
    idles(3);
`ifdef INSTR_ASM_RANGE_CHECK_EN
    chk("tp3 err", {31'b0, err8}, 32'd1); chk("tp3 mem0", mem8[0], EBRK);
`else
    chk("tp3 err", {31'b0, err8}, 32'd0); chk("tp3 mem0", mem8[0], 32'h8000_0093);
`endif

    // Overflow of the 4-word instance: five beats, no in_last.
    do_start();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd1, 3'd0, 7'(i), 5'(i), 5'd3, 5'd4, 0, 1'b0); tick();
    end
    idles(2);
    chk("ovf ready2", {31'b0, rdy2}, 32'd0); chk("ovf mem3", mem2[3], EBRK);
    chk("ovf err2", {31'b0, err2}, 32'd1);  chk("ovf done2", {31'b0, done2}, 32'd1);

    // Random valid gaps, illegal kind on beat 3.
    do_start();
    for (int i = 0; i < 2; i++) rand_beat(i, 1'b0, 1'b0);
    nb = 0; cyc = 0;
    while (nb < 3 && cyc < 100) begin
      drive(1'($urandom_range(0, 1)), (nb < 2) ? pk[nb] : 3'd7, pf3[nb % 2], pf7[nb % 2],
            prd[nb % 2], prs1[nb % 2], prs2[nb % 2], pimm[nb % 2], 1'b0);
      tick();
      if (last_hs) nb++;
      cyc++;
    end
    chk("rv beats", nb, 32'd3);
    idles(3);
    chk("rv mem2", mem8[2], EBRK); chk("rv err", {31'b0, err8}, 32'd1);

    // Random programs, start asserted together with a valid beat.
    for (int p = 0; p < 8; p++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) rand_beat(i, 1'b1, 1'b1);
      drive(1'b1, pk[0], pf3[0], pf7[0], prd[0], prs1[0], prs2[0], pimm[0], len == 1);
      do_start();
      nb = 0; cyc = 0;
      while (nb < len && m_acc[0] && cyc < 200) begin
        drive(1'($urandom_range(0, 1)), pk[nb], pf3[nb], pf7[nb], prd[nb], prs1[nb],
              prs2[nb], pimm[nb], nb == len - 1);
        tick();
        if (last_hs) nb++;
        cyc++;
      end
      chk("rp bounded", {31'b0, cyc < 200}, 32'd1);
      idles(3);
      chk("rp done8", {31'b0, done8}, 32'd1);
    end

    // Asynchronous reset mid-program.
    do_start();
    drive(1'b1, 3'd0, 3'd1, 7'd0, 5'd2, 5'd3, 5'd0, 7, 1'b0); tick(); tick(); tick();
    #2 rst_n = 1'b0; model_reset();
    #1 check_outs();
    chk("arst we", {31'b0, we8}, 32'd0); chk("arst wdata", wd8, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    do_start();
    drive(1'b1, 3'd5, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, -4, 1'b1); tick();
    chk("arst addr", {24'b0, addr8}, 32'd0); chk("arst we1", {31'b0, we8}, 32'd1);
    idles(3);
    chk("arst mem0", mem8[0], 32'hFFC0_80E7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
